serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Sequencer that performs WIDTH-bit addition on a single external 1-bit full
//   adder (x, y, cin -> sum, cout) by feeding it one bit pair per clock, LSB
//   first, and recirculating the carry.
//   Sits between a requester (start/done handshake) and the combinational full
//   adder, trading area for latency.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>= 2)
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request; sampled only in IDLE
//   a        in   WIDTH  operand A, captured when start accepted
//   b        in   WIDTH  operand B, captured when start accepted
//   cin      in   1      carry-in, captured when start accepted
//   busy     out  1      1 while in RUN or DONE
//   done     out  1      one-cycle pulse: sum/cout valid
//   sum      out  WIDTH  result register, updated only at completion
//   cout     out  1      final carry-out, updated only at completion
//   fa_x     out  1      to full adder x
//   fa_y     out  1      to full adder y
//   fa_cin   out  1      to full adder cin
//   fa_sum   in   1      from full adder sum (combinational)
//   fa_cout  in   1      from full adder cout (combinational)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; busy, done, sum, cout, fa_* all 0;
//     internal shift regs, carry and bit counter cleared.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE -> RUN on an edge with start=1.
//       * latch a and b into shift regs and cin into the carry reg;
//       * set bit counter to 0.
//     RUN: at each edge
//       * shift fa_sum into the partial-sum reg MSB (right shift);
//       * carry <= fa_cout;
//       * shift both operands right by 1;
//       * counter++.
//       After the edge with counter==WIDTH-1:
//       * sum <= completed partial sum;
//       * cout <= fa_cout;
//       * state -> DONE.
//     DONE -> IDLE unconditionally after one cycle.
//   - fa_x = a_sh[0], fa_y = b_sh[0], fa_cin = carry while in RUN.
//     All three are 0 in IDLE and DONE.
//   - done = 1 only in DONE.
//     Start accepted at edge E0 -> RUN for WIDTH cycles -> done high in the
//     cycle after edge E_WIDTH. Latency is WIDTH+1 cycles from acceptance to
//     the done pulse.
//   - busy = 1 in RUN and DONE. start is ignored whenever busy=1, including in
//     DONE; a new request needs a start in IDLE. Back-to-back period is
//     WIDTH+2 cycles.
//   - a/b/cin changes after acceptance have no effect on the running operation.
//   - sum/cout hold the last completed result until the next completion.
//     They do not change at acceptance.
//   - Result equals {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
//     Wrap-around appears as sum wrapping with cout=1.
//   - Reset mid-RUN aborts immediately: no done pulse, and sum/cout cleared
//     to 0.
// TESTING
//   - WIDTH=8, a=0x5A b=0x3C cin=0 -> done exactly 9 cycles after the accept
//     edge, sum=0x96, cout=0, busy high for 9 cycles.
//   - a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; a=0xFF b=0x00 cin=1 -> sum=0x00
//     cout=1.
//   - start held high through RUN/DONE with new a/b -> no restart, result from
//     the first operands only; next accept only in IDLE.
//   - rst_n pulsed low at bit 4 of a=0xAA+0x55 -> all outputs 0 immediately,
//     no done; a fresh start then gives sum=0xFF cout=0.
//   - Bench-side full-adder model; check fa_x/fa_y/fa_cin bit order
//     (LSB first) and 0 in IDLE/DONE.
//   - WIDTH=3: exhaustive 128 (a,b,cin) combos vs behavioural a+b+cin;
//     done count equals request count.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial WIDTH-bit adder sequencer driving one external 1-bit full adder, LSB first.
// Latency : done pulses WIDTH+1 cycles after start is accepted; back-to-back period WIDTH+2 cycles.
// Backpr. : start is sampled only in IDLE; requests while busy (RUN or DONE) are ignored.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, a, b, cin    request and operands, captured when start is accepted in IDLE
//   busy, done          busy in RUN/DONE; done is a one-cycle pulse when sum/cout are valid
//   sum, cout           last completed result, updated only at completion
//   fa_x, fa_y, fa_cin  operand bits and carry presented to the external full adder
//   fa_sum, fa_cout     combinational results from the external full adder
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic [WIDTH-1:0] psum_nxt;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign psum_nxt = {fa_sum, psum[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        fa_x      = 1'b0;
        fa_y      = 1'b0;
        fa_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                fa_x   = a_sh[0];
                fa_y   = b_sh[0];
                fa_cin = carry;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    psum  <= psum_nxt;
                    carry <= fa_cout;
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= psum_nxt;
                        cout <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       fa_x;
    logic       fa_y;
    logic       fa_cin;
    logic       fa_sum;
    logic       fa_cout;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       cin3;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;
    logic       fa_x3;
    logic       fa_y3;
    logic       fa_cin3;
    logic       fa_sum3;
    logic       fa_cout3;

    int n_cmp = 0;
    int n_err = 0;
    int dn3   = 0;

    always #5 clk = ~clk;

    // Behavioural full adders
    assign fa_sum   = fa_x ^ fa_y ^ fa_cin;
    assign fa_cout  = (fa_x & fa_y) | (fa_cin & (fa_x ^ fa_y));
    assign fa_sum3  = fa_x3 ^ fa_y3 ^ fa_cin3;
    assign fa_cout3 = (fa_x3 & fa_y3) | (fa_cin3 & (fa_x3 ^ fa_y3));

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    serial_add_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3),
        .fa_x(fa_x3), .fa_y(fa_y3), .fa_cin(fa_cin3), .fa_sum(fa_sum3), .fa_cout(fa_cout3)
    );

    always @(negedge clk) begin
        if (done3 === 1'b1) dn3++;
    end

    // Starts and ends 1 time unit after a rising edge. Returns result,
    // edges from accept to first done sample, and busy cycles seen.
    task automatic do_add8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                           output logic [7:0] os, output logic oc,
                           output int edges, output int busy_cyc);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && edges < 30) begin
            @(posedge clk); #1;
            edges++;
            if (busy === 1'b1) busy_cyc++;
        end
        os = sum; oc = cout;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        #12;
        n_cmp++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            n_err++; $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
        end
        n_cmp++;
        if ({fa_x, fa_y, fa_cin} !== 3'b000) begin
            n_err++; $display("FAIL reset_fa: got %b, want 000", {fa_x, fa_y, fa_cin});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_basic;
        logic [7:0] s; logic c; int e; int bc;
        do_add8(8'h5A, 8'h3C, 1'b0, s, c, e, bc);
        n_cmp++;
        if (e !== 8) begin
            n_err++; $display("FAIL basic_latency: got %0d edges after accept, want 8 (done in 9th cycle)", e);
        end
        n_cmp++;
        if ({c, s} !== 9'h096) begin
            n_err++; $display("FAIL basic_result: got cout=%b sum=%h, want cout=0 sum=96", c, s);
        end
        n_cmp++;
        if (bc !== 9) begin
            n_err++; $display("FAIL basic_busy_cycles: got %0d, want 9", bc);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL basic_back_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
        n_cmp++;
        if ({cout, sum} !== 9'h096) begin
            n_err++; $display("FAIL basic_hold: got cout=%b sum=%h, want 0 96", cout, sum);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] s; logic c; int e; int bc;
        do_add8(8'hFF, 8'h01, 1'b0, s, c, e, bc);
        n_cmp++;
        if ({c, s} !== 9'h100) begin
            n_err++; $display("FAIL wrap_ff_01: got cout=%b sum=%h, want 1 00", c, s);
        end
        do_add8(8'hFF, 8'h00, 1'b1, s, c, e, bc);
        n_cmp++;
        if ({c, s} !== 9'h100) begin
            n_err++; $display("FAIL wrap_ff_00_c1: got cout=%b sum=%h, want 1 00", c, s);
        end
        do_add8(8'h80, 8'h80, 1'b1, s, c, e, bc);
        n_cmp++;
        if ({c, s} !== 9'h101) begin
            n_err++; $display("FAIL wrap_80_80_c1: got cout=%b sum=%h, want 1 01", c, s);
        end
    endtask

    task automatic test_start_held;
        int e;
        // previous result is 0x101; it must survive acceptance
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({cout, sum} !== 9'h101) begin
            n_err++; $display("FAIL held_sum_at_accept: got cout=%b sum=%h, want 1 01", cout, sum);
        end
        a = 8'h77; b = 8'h11;
        e = 0;
        while (done !== 1'b1 && e < 30) begin
            @(posedge clk); #1; e++;
        end
        n_cmp++;
        if (e !== 8 || {cout, sum} !== 9'h046) begin
            n_err++; $display("FAIL held_first_result: got edges=%0d cout=%b sum=%h, want 8 0 46", e, cout, sum);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL held_no_restart_in_done: got busy=%b, want 0", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL held_accept_in_idle: got busy=%b, want 1", busy);
        end
        e = 0;
        while (done !== 1'b1 && e < 30) begin
            @(posedge clk); #1; e++;
        end
        n_cmp++;
        if (e !== 8 || {cout, sum} !== 9'h088) begin
            n_err++; $display("FAIL held_second_result: got edges=%0d cout=%b sum=%h, want 8 0 88", e, cout, sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bit_order;
        logic [7:0] ta; logic [7:0] tb; logic c; int e;
        ta = 8'hB4; tb = 8'h2D; c = 1'b1;
        n_cmp++;
        if ({fa_x, fa_y, fa_cin} !== 3'b000) begin
            n_err++; $display("FAIL order_idle_fa: got %b, want 000", {fa_x, fa_y, fa_cin});
        end
        a = ta; b = tb; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({fa_x, fa_y, fa_cin} !== {ta[k], tb[k], c}) begin
                n_err++; $display("FAIL order_bit%0d: got %b, want %b", k, {fa_x, fa_y, fa_cin}, {ta[k], tb[k], c});
            end
            c = (ta[k] & tb[k]) | (c & (ta[k] ^ tb[k]));
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done !== 1'b1 || {fa_x, fa_y, fa_cin} !== 3'b000 || {cout, sum} !== 9'h0E2) begin
            n_err++; $display("FAIL order_done_fa: got done=%b fa=%b cout=%b sum=%h, want 1 000 0 e2",
                              done, {fa_x, fa_y, fa_cin}, cout, sum);
        end
        @(posedge clk); #1;
        e = 0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] s; logic c; int e; int bc; int seen;
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_cmp++;
        if ({fa_x, fa_y} !== 2'b01) begin
            n_err++; $display("FAIL mid_bit4_operands: got %b, want 01", {fa_x, fa_y});
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, cout, sum, fa_x, fa_y, fa_cin} !== 14'd0) begin
            n_err++; $display("FAIL mid_reset_clear: got busy=%b done=%b cout=%b sum=%h fa=%b, want all 0",
                              busy, done, cout, sum, {fa_x, fa_y, fa_cin});
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL mid_no_done: got %0d done pulses, want 0", seen);
        end
        do_add8(8'hAA, 8'h55, 1'b0, s, c, e, bc);
        n_cmp++;
        if ({c, s} !== 9'h0FF || e !== 8) begin
            n_err++; $display("FAIL mid_fresh_result: got cout=%b sum=%h edges=%0d, want 0 ff 8", c, s, e);
        end
    endtask

    task automatic test_w3_exhaustive;
        int e; int req; int d0;
        logic [3:0] want;
        req = 0;
        d0 = dn3;
        for (int i = 0; i < 128; i++) begin
            a3 = i[2:0]; b3 = i[5:3]; cin3 = i[6]; start3 = 1'b1;
            want = {1'b0, a3} + {1'b0, b3} + {3'b000, cin3};
            @(posedge clk); #1;
            start3 = 1'b0;
            req++;
            e = 0;
            while (done3 !== 1'b1 && e < 10) begin
                @(posedge clk); #1; e++;
            end
            n_cmp++;
            if ({cout3, sum3} !== want || e !== 3) begin
                n_err++; $display("FAIL w3_add a=%0d b=%0d cin=%0d: got %0d edges=%0d, want %0d edges=3",
                                  i[2:0], i[5:3], i[6], {cout3, sum3}, e, want);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dn3 - d0 !== req) begin
            n_err++; $display("FAIL w3_done_count: got %0d, want %0d", dn3 - d0, req);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_start_held();
        test_bit_order();
        test_reset_mid();
        test_w3_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
